mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified RAM between IF (instruction fetch) and MEM (load/store) of the
//  5-stage pipeline. Grants one access at a time and holds it for a fixed RAM latency. Drives

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_wait_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-RAM arbiter, its wait counter and the RAM model.
// State encoding is fixed so the bench and RAM model can decode it.
// Busy-counter width helper keeps LATENCY=1 at a legal one-bit counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_I = 2'd2
    } arb_state_t;

    localparam int MEM_LATENCY = 2;

    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Counts the remaining cycles of one RAM access; zero marks the last busy cycle.
// Latency: load/decrement take effect at the next clock edge.
// No backpressure: load has priority over decrement.
module arb_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int  LATENCY = MEM_LATENCY,
    localparam int CW      = cnt_width(LATENCY)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LATENCY - 1);
        end else if (dec) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch and the MEM stage, MEM first.
// Latency: LATENCY cycles per access plus one grant cycle; back-to-back accesses skip idle.
// Backpressure: stall_o freezes the pipeline until every pending request has completed.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              stall_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int CW = cnt_width(LATENCY);

    arb_state_t    state;
    logic          if_done;
    logic          d_done;
    logic          d_req;
    logic          d_pend;
    logic          if_pend;
    logic          busy;
    logic          done_now;
    logic          grant_d;
    logic          grant_i;
    logic          cnt_zero;
    logic [CW-1:0] cnt;

    assign d_req    = d_read_i | d_write_i;
    assign d_pend   = d_req & ~d_done;
    assign if_pend  = if_req_i & ~if_done;
    assign busy     = (state != ARB_IDLE);
    assign done_now = busy & cnt_zero;
    assign stall_o  = busy | d_pend | if_pend;

    // A completing access hands the port straight to the other side if it is waiting.
    assign grant_d = d_pend & ((state == ARB_IDLE) | ((state == ARB_BUSY_I) & cnt_zero));
    assign grant_i = if_pend & (((state == ARB_IDLE) & ~d_pend) |
                                ((state == ARB_BUSY_D) & cnt_zero));

    arb_wait_counter #(
        .LATENCY (LATENCY)
    ) u_wait_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (~busy | done_now),
        .dec   (busy & ~cnt_zero),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ARB_IDLE;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            if_data_o   <= '0;
            d_rdata_o   <= '0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            // Pipeline advances this edge: served requests belong to the old instructions.
            if (!stall_o) begin
                if_done <= 1'b0;
                d_done  <= 1'b0;
            end

            if (done_now) begin
                if (state == ARB_BUSY_D) begin
                    if (!ram_we_o) begin
                        d_rdata_o <= ram_rdata_i;
                    end
                    d_done <= 1'b1;
                end else if (state == ARB_BUSY_I) begin
                    if_data_o <= ram_rdata_i;
                    if_done   <= 1'b1;
                end
            end

            if (grant_d) begin
                state       <= ARB_BUSY_D;
                ram_en_o    <= 1'b1;
                ram_we_o    <= d_write_i;
                ram_addr_o  <= d_addr_i;
                ram_wdata_o <= d_wdata_i;
            end else if (grant_i) begin
                state      <= ARB_BUSY_I;
                ram_en_o   <= 1'b1;
                ram_we_o   <= 1'b0;
                ram_addr_o <= if_addr_i;
            end else if (done_now) begin
                state    <= ARB_IDLE;
                ram_en_o <= 1'b0;
                ram_we_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: pipeline-step driver with a reference memory, decoupled monitor.
// Two instances (LATENCY=2 and LATENCY=1) share stimulus; sel picks the one being checked.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_init_req;

    logic [31:0] if_data0, d_rdata0, ram_addr0, ram_wdata0, ram_rdata0;
    logic [31:0] if_data1, d_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        stall0, ram_en0, ram_we0;
    logic        stall1, ram_en1, ram_we1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(MEM_LATENCY)) dut0 (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data0),
        .d_read_i(d_read), .d_write_i(d_write), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata0), .stall_o(stall0),
        .ram_en_o(ram_en0), .ram_we_o(ram_we0), .ram_addr_o(ram_addr0),
        .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data1),
        .d_read_i(d_read), .d_write_i(d_write), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata1), .stall_o(stall1),
        .ram_en_o(ram_en1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1),
        .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        if (i == 16) return 32'h8C01_0004;
        return 32'hA500_0000 ^ (v * 32'h0001_0003) ^ {v[7:0], 24'h0};
    endfunction

    // Word-addressed RAM models, read data combinational (valid in the last busy cycle).
    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];
    assign ram_rdata0 = ram0[ram_addr0[9:2]];
    assign ram_rdata1 = ram1[ram_addr1[9:2]];

    always @(posedge clk) begin
        if (mem_init_req) begin
            for (int i = 0; i < 256; i++) begin
                ram0[i] <= init_word(i);
                ram1[i] <= init_word(i);
            end
        end else begin
            if (ram_en0 && ram_we0) ram0[ram_addr0[9:2]] <= ram_wdata0;
            if (ram_en1 && ram_we1) ram1[ram_addr1[9:2]] <= ram_wdata1;
        end
    end

    bit          sel = 1'b0;
    logic        o_stall, o_en, o_we;
    logic [31:0] o_if, o_d, o_addr, o_wdata;
    assign o_stall = sel ? stall1     : stall0;
    assign o_en    = sel ? ram_en1    : ram_en0;
    assign o_we    = sel ? ram_we1    : ram_we0;
    assign o_if    = sel ? if_data1   : if_data0;
    assign o_d     = sel ? d_rdata1   : d_rdata0;
    assign o_addr  = sel ? ram_addr1  : ram_addr0;
    assign o_wdata = sel ? ram_wdata1 : ram_wdata0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One expected pipeline step: accesses in service order (MEM before IF).
    typedef struct {
        int          n_acc;
        logic [31:0] addr0;
        logic [31:0] addr1;
        bit          we0;
        logic [31:0] wdata;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
    } item_t;

    item_t       sb_q[$];
    bit          mon_on = 1'b0;
    logic [31:0] ref_mem [256];
    logic [31:0] model_if;
    logic [31:0] model_d;

    function automatic int cur_lat();
        return sel ? 1 : MEM_LATENCY;
    endfunction

    // Monitor: checks every RAM cycle against the step's access list, closes a step on stall_o=0.
    initial begin
        int    st_cnt;
        int    en_cnt;
        int    ram_bad;
        int    idx;
        item_t it;
        st_cnt = 0; en_cnt = 0; ram_bad = 0;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                st_cnt = 0; en_cnt = 0; ram_bad = 0;
            end else begin
                if (o_en) begin
                    if (sb_q.size() == 0) begin
                        ram_bad++;
                    end else begin
                        it  = sb_q[0];
                        idx = en_cnt / cur_lat();
                        if (idx >= it.n_acc) ram_bad++;
                        else if (o_addr !== (idx == 0 ? it.addr0 : it.addr1)) ram_bad++;
                        else if (o_we !== (idx == 0 && it.we0)) ram_bad++;
                        else if (o_we && o_wdata !== it.wdata) ram_bad++;
                    end
                    en_cnt++;
                end
                if (o_stall) begin
                    st_cnt++;
                end else if (sb_q.size() == 0) begin
                    check("step_without_expectation", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    check("stall_cycles", 32'(st_cnt), 32'(it.n_acc == 0 ? 0 : it.n_acc * cur_lat() + 1));
                    check("ram_en_cycles", 32'(en_cnt), 32'(it.n_acc * cur_lat()));
                    check("ram_sequence_errors", 32'(ram_bad), 32'd0);
                    check("if_data", o_if, it.exp_if);
                    check("d_rdata", o_d, it.exp_d);
                    st_cnt = 0; en_cnt = 0; ram_bad = 0;
                end
            end
        end
    end

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_init_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_init_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_if = '0;
        model_d  = '0;
    endtask

    // dk: 0 no data access, 1 load, 2 store. flush drops all requests once the access is granted.
    task automatic step(input bit do_if, input logic [31:0] ia, input int dk,
                        input logic [31:0] da, input logic [31:0] wd, input bit flush);
        item_t it;
        bit    ok;
        it.n_acc = 0; it.addr0 = '0; it.addr1 = '0; it.we0 = 1'b0; it.wdata = wd;
        if (dk != 0) begin
            it.addr0 = da;
            it.n_acc = 1;
            if (dk == 2) begin
                it.we0 = 1'b1;
                ref_mem[da[9:2]] = wd;
            end else begin
                model_d = ref_mem[da[9:2]];
            end
        end
        if (do_if) begin
            if (it.n_acc == 0) it.addr0 = ia; else it.addr1 = ia;
            it.n_acc++;
            model_if = ref_mem[ia[9:2]];
        end
        it.exp_if = model_if;
        it.exp_d  = model_d;

        @(posedge clk);
        #1;
        sb_q.push_back(it);
        mon_on  = 1'b1;
        if_req  = do_if;
        if_addr = ia;
        d_read  = (dk == 1);
        d_write = (dk == 2);
        d_addr  = da;
        d_wdata = wd;

        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!o_stall) begin
                ok = 1'b1;
                break;
            end
            if (flush && c == 0) begin
                @(posedge clk);
                #1;
                if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
            end
        end
        if (!ok) begin
            check("step_timeout", 32'd1, 32'd0);
            finish_run();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic random_steps(input int n);
        bit          do_if;
        int          dk;
        bit          flush;
        logic [31:0] ia;
        logic [31:0] da;
        for (int k = 0; k < n; k++) begin
            do_if = ($urandom_range(0, 3) != 0);
            dk    = $urandom_range(0, 2);
            ia    = rand_addr();
            da    = rand_addr();
            flush = ((do_if ? 1 : 0) + (dk != 0 ? 1 : 0) == 1) && ($urandom_range(0, 3) == 0);
            step(do_if, ia, dk, da, $urandom(), flush);
        end
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        #2;
        check("reset_stall", 32'(stall0), 32'd0);
        check("reset_ram_en", 32'(ram_en0), 32'd0);
        check("reset_ram_we", 32'(ram_we0), 32'd0);
        check("reset_ram_addr", ram_addr0, 32'd0);
        check("reset_if_data", if_data0, 32'd0);
        check("reset_d_rdata", d_rdata0, 32'd0);

        // Reset arriving in the middle of a store.
        @(posedge clk);
        #1;
        d_write = 1'b1; d_addr = 32'h3F0; d_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("store_busy_en", 32'(ram_en0), 32'd1);
        check("store_busy_we", 32'(ram_we0), 32'd1);
        #2;
        rst_n = 1'b0;
        d_write = 1'b0;
        #1;
        check("async_reset_en", 32'(ram_en0), 32'd0);
        check("async_reset_we", 32'(ram_we0), 32'd0);
        check("async_reset_stall", 32'(stall0), 32'd0);

        do_reset();
        step(1'b1, 32'h40, 0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h40, 1, 32'h100, 32'h0, 1'b0);
        step(1'b0, 32'h0, 2, 32'h200, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h0, 1, 32'h200, 32'h0, 1'b0);
        step(1'b1, 32'h80, 0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'h80, 0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1, 32'h44, 32'h0, 1'b1);
        step(1'b1, 32'h44, 1, 32'h44, 32'h0, 1'b0);
        random_steps(150);
        @(posedge clk);
        mon_on = 1'b0;

        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(1'b1, rand_addr(), (k % 2 == 1) ? 1 : 0, rand_addr(), 32'h0, 1'b0);
        end
        step(1'b0, 32'h0, 2, 32'h200, 32'hCAFE_F00D, 1'b0);
        step(1'b1, 32'h200, 1, 32'h200, 32'h0, 1'b0);
        random_steps(80);
        @(posedge clk);
        mon_on = 1'b0;

        finish_run();
    end

endmodule
